// File: rtl/cdru_rr_if.sv
// Read-request bundle between the requesters and the conflict detection read unit.
//   master : requester side; drives req_en/req_addr and sees grants, bank drive, responses.
//   slave  : the unit; consumes requests and drives grants, bank drive, responses, counter.
// Address slice k of req_addr is [k*A +: A]; the bank index is its upper BANKBITS.
interface cdru_rr_if #(
    parameter int NREQ     = 3,
    parameter int BANKBITS = 5,
    parameter int WORDBITS = 10,
    parameter int CNTW     = 16
);
    localparam int A     = BANKBITS + WORDBITS;
    localparam int NBANK = 1 << BANKBITS;

    logic [NREQ-1:0]           req_en;
    logic [NREQ*A-1:0]         req_addr;
    logic [NREQ-1:0]           req_grnt;
    logic [NBANK-1:0]          bank_en;
    logic [NBANK*WORDBITS-1:0] bank_addr;
    logic [NREQ-1:0]           rsp_vld;
    logic [NREQ*BANKBITS-1:0]  rsp_bank;
    logic [CNTW-1:0]           conflict_cnt;

    modport master (
        output req_en, req_addr,
        input  req_grnt, bank_en, bank_addr, rsp_vld, rsp_bank, conflict_cnt
    );

    modport slave (
        input  req_en, req_addr,
        output req_grnt, bank_en, bank_addr, rsp_vld, rsp_bank, conflict_cnt
    );
endinterface

// File: rtl/cdru_rr.sv
// Conflict detection read unit for the banked scratchpad.
// Each cycle grants a conflict-free subset of reads (at most one per bank), drives
// per-bank enable/word address, and carries {grant, bank} down an RDLAT-deep pipe so
// read data can be steered back. Priority scan starts at ptr; in rotating mode ptr
// advances on every cycle with a denial, bounding starvation to NREQ-1 conflict cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cdru_rr_if.slave (requests in; grants, bank drive, responses, counter out)
module cdru_rr #(
    parameter int NREQ      = 3,
    parameter int BANKBITS  = 5,
    parameter int WORDBITS  = 10,
    parameter int RDLAT     = 1,
    parameter int PRIO_MODE = 1,
    parameter int CNTW      = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    cdru_rr_if.slave  bus
);
    localparam int A     = BANKBITS + WORDBITS;
    localparam int NBANK = 1 << BANKBITS;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]                     ptr;
    logic [NREQ-1:0][BANKBITS-1:0]     bank_of;
    logic [NREQ-1:0][WORDBITS-1:0]     word_of;
    logic [NREQ-1:0][PW-1:0]           pos;
    logic [NREQ-1:0]                   blocked;
    logic [NREQ-1:0]                   grnt;
    logic [NREQ-1:0][BANKBITS-1:0]     bank_gated;
    logic                              denied;
    logic [NBANK-1:0]                  bank_en;
    logic [NBANK*WORDBITS-1:0]         bank_addr;
    logic [RDLAT-1:0][NREQ-1:0]        vld_pipe;
    logic [RDLAT-1:0][NREQ-1:0][BANKBITS-1:0] bank_pipe;
    logic [CNTW-1:0]                   cnt;

    // Split addresses and compute each requester's position in the scan order.
    always_comb begin
        int p;
        p = 0;
        for (int k = 0; k < NREQ; k++) begin
            bank_of[k] = bus.req_addr[k*A+WORDBITS +: BANKBITS];
            word_of[k] = bus.req_addr[k*A +: WORDBITS];
            p = k - int'(ptr);
            if (p < 0) p = p + NREQ;
            pos[k] = PW'(p);
        end
    end

    // A requester loses if any enabled requester earlier in scan order hits its bank.
    always_comb begin
        blocked = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (j != k && bus.req_en[j] && bank_of[j] == bank_of[k] && pos[j] < pos[k])
                    blocked[k] = 1'b1;
            end
        end
        grnt   = bus.req_en & ~blocked;
        denied = |(bus.req_en & ~grnt);
    end

    // Winners are unique per bank, so plain overwrite is safe. Denied banks are
    // zeroed before the pipe so no state ever depends on denied addresses.
    always_comb begin
        bank_en    = '0;
        bank_addr  = '0;
        bank_gated = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grnt[k]) begin
                bank_en[bank_of[k]]                                 = 1'b1;
                bank_addr[int'(bank_of[k])*WORDBITS +: WORDBITS]    = word_of[k];
                bank_gated[k]                                       = bank_of[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            vld_pipe  <= '0;
            bank_pipe <= '0;
        end else begin
            if (PRIO_MODE == 0)
                ptr <= '0;
            else if (denied)
                ptr <= (ptr == PW'(NREQ-1)) ? '0 : ptr + 1'b1;

            if (denied && cnt != {CNTW{1'b1}})
                cnt <= cnt + 1'b1;

            vld_pipe[0]  <= grnt;
            bank_pipe[0] <= bank_gated;
            for (int s = 1; s < RDLAT; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                bank_pipe[s] <= bank_pipe[s-1];
            end
        end
    end

    assign bus.req_grnt     = grnt;
    assign bus.bank_en      = bank_en;
    assign bus.bank_addr    = bank_addr;
    assign bus.rsp_vld      = vld_pipe[RDLAT-1];
    assign bus.rsp_bank     = bank_pipe[RDLAT-1];
    assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_cdru_rr.sv
// Bench for cdru_rr: two instances (rotating/RDLAT=3/CNTW=4 and fixed/RDLAT=1/CNTW=16)
// share one request stream and are checked against a per-cycle scan model.
module tb_cdru_rr;
    localparam int NREQ = 3, BB = 5, WB = 10, A = 15, NBANK = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_en;
    logic [NREQ*A-1:0] req_addr;

    cdru_rr_if #(.NREQ(NREQ), .BANKBITS(BB), .WORDBITS(WB), .CNTW(4))  bus0 ();
    cdru_rr_if #(.NREQ(NREQ), .BANKBITS(BB), .WORDBITS(WB), .CNTW(16)) bus1 ();

    assign bus0.req_en = req_en;  assign bus0.req_addr = req_addr;
    assign bus1.req_en = req_en;  assign bus1.req_addr = req_addr;

    cdru_rr #(.NREQ(NREQ), .BANKBITS(BB), .WORDBITS(WB), .RDLAT(3), .PRIO_MODE(1), .CNTW(4))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    cdru_rr #(.NREQ(NREQ), .BANKBITS(BB), .WORDBITS(WB), .RDLAT(1), .PRIO_MODE(0), .CNTW(16))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int n_chk = 0, n_fail = 0;
    int RDL[2]  = '{3, 1};
    int PM[2]   = '{1, 0};
    int CMAX[2] = '{15, 65535};
    int mptr[2], mcnt[2], cyc;
    logic [NREQ-1:0]    hist_g[2][4096];
    logic [NREQ*BB-1:0] hist_b[2][4096];
    logic [NREQ-1:0]    lastg[2];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic setreq(input int k, input bit en, input int bank, input int word);
        req_en[k] = en;
        req_addr[k*A +: A] = {5'(bank), 10'(word)};
    endtask

    // One cycle: check outputs at the falling edge, then advance the model.
    task automatic step();
        logic [NREQ-1:0] g, ev, gg, gv;
        logic [NBANK-1:0] ben, claimed, gbe;
        logic [NBANK*WB-1:0] baddr, gba;
        logic [NREQ*BB-1:0] gb, eb, grb, mask;
        logic [15:0] gc;
        bit den;
        int k, b;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            g = '0; ben = '0; baddr = '0; gb = '0; claimed = '0; den = 0;
            for (int i = 0; i < NREQ; i++) begin
                k = (mptr[d] + i) % NREQ;
                if (req_en[k]) begin
                    b = int'(req_addr[k*A+WB +: BB]);
                    if (claimed[b]) den = 1;
                    else begin
                        claimed[b] = 1'b1; g[k] = 1'b1; ben[b] = 1'b1;
                        baddr[b*WB +: WB] = req_addr[k*A +: WB];
                        gb[k*BB +: BB] = 5'(b);
                    end
                end
            end
            if (d == 0) begin
                gg = bus0.req_grnt; gbe = bus0.bank_en; gba = bus0.bank_addr;
                gv = bus0.rsp_vld;  grb = bus0.rsp_bank; gc = 16'(bus0.conflict_cnt);
            end else begin
                gg = bus1.req_grnt; gbe = bus1.bank_en; gba = bus1.bank_addr;
                gv = bus1.rsp_vld;  grb = bus1.rsp_bank; gc = bus1.conflict_cnt;
            end
            ev = (cyc >= RDL[d]) ? hist_g[d][cyc-RDL[d]] : '0;
            eb = (cyc >= RDL[d]) ? hist_b[d][cyc-RDL[d]] : '0;
            for (int j = 0; j < NREQ; j++) mask[j*BB +: BB] = {BB{ev[j]}};
            chk($sformatf("d%0d_c%0d_grnt", d, cyc), 512'(gg), 512'(g));
            chk($sformatf("d%0d_c%0d_bank_en", d, cyc), 512'(gbe), 512'(ben));
            chk($sformatf("d%0d_c%0d_bank_addr", d, cyc), 512'(gba), 512'(baddr));
            chk($sformatf("d%0d_c%0d_rsp_vld", d, cyc), 512'(gv), 512'(ev));
            chk($sformatf("d%0d_c%0d_rsp_bank", d, cyc), 512'(grb & mask), 512'(eb & mask));
            chk($sformatf("d%0d_c%0d_cnt", d, cyc), 512'(gc), 512'(mcnt[d]));
            hist_g[d][cyc] = g; hist_b[d][cyc] = gb; lastg[d] = g;
            if (den) begin
                if (mcnt[d] < CMAX[d]) mcnt[d]++;
                if (PM[d] == 1) mptr[d] = (mptr[d] + 1) % NREQ;
            end
        end
        if (cyc < 4095) cyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_en = '0;
        mptr = '{0, 0}; mcnt = '{0, 0}; cyc = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_vld0", 512'(bus0.rsp_vld), 512'(0));
            chk("rst_vld1", 512'(bus1.rsp_vld), 512'(0));
            chk("rst_cnt0", 512'(bus0.conflict_cnt), 512'(0));
            chk("rst_cnt1", 512'(bus1.conflict_cnt), 512'(0));
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] held;
        req_en = '0; req_addr = '0;
        do_reset();

        // Distinct banks 1,2,3: all granted, responses after each latency.
        setreq(0, 1, 1, 11); setreq(1, 1, 2, 22); setreq(2, 1, 3, 33);
        step();
        req_en = '0;
        repeat (3) step();

        // All three on bank 7, held: rotation in one unit, fixed winner in the other.
        setreq(0, 1, 7, 100); setreq(1, 1, 7, 200); setreq(2, 1, 7, 300);
        repeat (6) step();

        // req0 and req2 on bank 5 only.
        req_en = '0;
        setreq(0, 1, 5, 5); setreq(2, 1, 5, 6);
        repeat (4) step();

        // Persistent conflict to saturate the 4-bit counter.
        setreq(0, 1, 9, 1); setreq(1, 1, 9, 2); setreq(2, 1, 9, 3);
        repeat (20) step();

        // Back-to-back grants to req1 on banks 0..4.
        req_en = '0;
        for (int i = 0; i < 5; i++) begin
            setreq(1, 1, i, 40 + i);
            step();
        end
        req_en = '0;
        repeat (4) step();

        // Random traffic; denied requesters hold their request until granted by both units.
        for (int n = 0; n < 300; n++) begin
            held = req_en & ~(lastg[0] & lastg[1]);
            for (int k = 0; k < NREQ; k++)
                if (!held[k])
                    setreq(k, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 1023));
            step();
        end

        // Reset while a grant is in flight: the response must never appear.
        req_en = '0;
        setreq(0, 1, 4, 77);
        step();
        do_reset();
        req_en = '0;
        repeat (4) step();
        setreq(0, 1, 6, 1); setreq(1, 1, 6, 2);
        repeat (3) step();
        req_en = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
